dcache_dual_port_arbiter: RTL

//  Sits between the two MEM-stage lanes of the dual-issue pipeline and the single-port,

---
 rtl/dcache_dual_port_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dcache_dual_port_arbiter.sv
// dcache_dual_port_arbiter
//   Arbitrates the two MEM-stage lanes onto one word-indexed dcache port.
//   The dcache reads asynchronously and writes synchronously. The arbiter
//   converts byte addresses to word indices and handles big-endian
//   byte/half/word loads with sign or zero extension. Sub-word stores are
//   done as a read-modify-write within a single cycle. When both lanes are
//   active, lane0 is served first with a one-cycle stall, then lane1.
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   mN_re/we/size/signed        lane N request (N = 0, 1)
//   mN_addr, mN_wdata           byte address, right-justified store data
//   mN_rdata, mN_err            load result, request rejected
//   stall                       freeze IF..MEM this cycle
//   dc_re/we/addr/wdata/rdata   dcache port (dc_addr is a zero-extended word index)
module dcache_dual_port_arbiter #(
  parameter int unsigned DEPTH = 384,
  parameter int unsigned IDX_W = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_re,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic        m0_signed,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_re,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic        m1_signed,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        stall,
  output logic        dc_re,
  output logic        dc_we,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  input  logic [31:0] dc_rdata
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold0_q, hold0_d;

  // Address bits above the word index do not take part in decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:IDX_W+2], m1_addr[31:IDX_W+2]};

  function automatic logic lane_err(input logic re, input logic we,
                                    input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = (re && we) || (size == 2'b11) ||
          (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00) ||
          (32'(addr[IDX_W+1:2]) >= DEPTH);
    return (re || we) && bad;
  endfunction

  // Big-endian: offset 0 is the most significant byte/half.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                           input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (size)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    if (size == 2'b00) begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (off[1]) r[15:0]  = d[15:0];
      else        r[31:16] = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  logic        err0, err1, act0, act1, both, sel1, s_act;
  logic        s_re, s_we, s_signed;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, live;

  assign err0 = lane_err(m0_re, m0_we, m0_size, m0_addr);
  assign err1 = lane_err(m1_re, m1_we, m1_size, m1_addr);
  assign act0 = (m0_re || m0_we) && !err0;
  assign act1 = (m1_re || m1_we) && !err1;
  assign both = (state_q == IDLE) && act0 && act1;
  // Lane1 owns the port in SECOND, or in IDLE when it is the only active lane.
  assign sel1 = (state_q == SECOND) || (!act0 && act1);

  always_comb begin
    s_act    = sel1 ? act1      : act0;
    s_re     = sel1 ? m1_re     : m0_re;
    s_we     = sel1 ? m1_we     : m0_we;
    s_size   = sel1 ? m1_size   : m0_size;
    s_signed = sel1 ? m1_signed : m0_signed;
    s_addr   = sel1 ? m1_addr   : m0_addr;
    s_wdata  = sel1 ? m1_wdata  : m0_wdata;
  end

  assign live = (s_act && s_re) ? load_ext(dc_rdata, s_size, s_signed, s_addr[1:0]) : '0;

  always_comb begin
    stall    = reset && both;
    dc_re    = reset && s_act && (s_re || (s_we && s_size != 2'b10));
    dc_we    = reset && s_act && s_we;
    dc_addr  = 32'(s_addr[IDX_W+1:2]);
    dc_wdata = store_merge(dc_rdata, s_wdata, s_size, s_addr[1:0]);
    m0_err   = reset && err0;
    m1_err   = reset && err1;
    m0_rdata = '0;
    m1_rdata = '0;
    if (reset) begin
      if (state_q == SECOND) m0_rdata = hold0_q;
      else if (!sel1)        m0_rdata = live;
      if (sel1)              m1_rdata = live;
    end
  end

  always_comb begin
    state_d = state_q;
    hold0_d = hold0_q;
    case (state_q)
      IDLE: if (both) begin
        state_d = SECOND;
        hold0_d = live;
      end
      SECOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold0_q <= '0;
    end else begin
      state_q <= state_d;
      hold0_q <= hold0_d;
    end
  end

endmodule
